mul_div_unit: RTL
=================

# mul_div_unit

Iterative multiply/divide unit with HI/LO registers for the EX stage of the 5-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU as multi-cycle operations, plus single-cycle MTHI/MTLO. While an operation is in flight it raises a stall request so the pipeline holds the instruction in EX. It is parametrised in data width and multiply latency, and supports mid-operation flush.

## Interface

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- MUL_LAT, 3, multiply latency in cycles, ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  EX holds a valid MDU instruction
- op  in  3  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO
- src1  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src2  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  abort in-flight operation
- stall_req  out  1  pipeline must hold IF/ID/EX
- busy  out  1  mul/div in flight
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation

- The FSM has four states: IDLE, MUL, DIV, DONE. Reset puts it in IDLE with hi=lo=0 and busy=done=0.
- **IDLE, start, op=MULT/MULTU:** latch the operands, load the counter with MUL_LAT, go to MUL.
- **IDLE, start, op=DIV/DIVU:** latch the operand magnitudes and the result signs (signed ops only), go to DIV.
- **IDLE, start, op=MTHI/MTLO:** hi or lo ← src1 at the next edge. The FSM stays in IDLE.
- **MUL:**
  - The product is computed from the latched operands: signed for MULT, unsigned for MULTU, 2·WIDTH bits wide.
  - The counter decrements each cycle. On expiry, {hi,lo} ← product and the FSM goes to DONE.
- **DIV:**
  - Restoring divider on magnitudes, one quotient bit per cycle, WIDTH cycles.
  - One further fix-up cycle applies signs:
    - quotient negated when the operand signs differ;
    - remainder takes the dividend's sign.
  - Result: hi ← remainder, lo ← quotient, then go to DONE.
- **Divide by zero:** hi ← src1 and lo ← all-ones, after the same full latency.
- **Signed INT_MIN / −1:** lo = INT_MIN, hi = 0. This falls out naturally from the magnitude algorithm with WIDTH-bit truncation.
- **DONE:**
  - done=1 for the cycle.
  - start is ignored, because it is the same instruction now retiring.
  - The FSM goes to IDLE unconditionally.
- **flush:**
  - From MUL/DIV/DONE: go to IDLE next cycle. hi/lo are not written.
  - start in the same cycle as flush is ignored.
- **stall_req** = busy | (state==IDLE & start & op∈{MULT,MULTU,DIV,DIVU} & !flush). It is combinational.
- Because stall_req is high while busy, MTHI/MTLO arriving during an operation stall until IDLE.
- **rst mid-operation:** abort, and hi/lo return to 0.

## Timing

- Accept edge k: start is sampled in IDLE.
- busy is 1 from after edge k until the edge at which hi/lo are written.
- Write edge:
  - multiply: k+MUL_LAT;
  - divide: k+WIDTH+1 (33 for WIDTH=32).
- done is high for the one cycle after the write edge; busy is 0 in that cycle.
- The first cycle at which a new mul/div can be accepted is write edge + 2. Back-to-back mul/div therefore costs one bubble (the DONE cycle).
- MTHI/MTLO take effect at the next edge, with no stall and no done.
- hi/lo are plain register outputs, so the value is visible the cycle after the write edge.
- Reading HI/LO after a mul/div sees the new value once the instruction has left EX.

## Structure

- The op codes (MDU_* `define, 3 bits) go in define.v next to the existing ALU op codes.
- Sub-module div_core:
  - the WIDTH-iteration restoring divider;
  - inputs: clk, rst, start, abort, dividend/divisor magnitudes;
  - outputs: quotient, remainder, valid.
- The sign fix-up and the divide-by-zero override stay in the top.
- The multiplier is a behavioural `*` inside mul_div_unit, with a delay counter.

## Test plan

- MULT src1=0xFFFFFFFD (−3), src2=5 → done at k+3+1; hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_req high for cycles k..k+2.
- MULTU 0xFFFFFFFF×2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV −7/2 → after 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/0 → hi=100, lo=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Start DIV with hi=0x11, lo=0x22, assert flush 10 cycles later → busy=0 next cycle, hi/lo unchanged, done never pulses, next start accepted.
- MTHI 0xABCD issued while DIV busy → stalls; start held through DONE (ignored), then MTHI written at the first IDLE edge; hi=0xABCD, lo=the div quotient.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared op codes, FSM state type and op-class helpers
// for the multiply/divide unit.
//   mdu_op_e    - 3-bit MDU op codes driven on mul_div_unit.op
//   mdu_state_e - control FSM states of mul_div_unit
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // True for the multi-cycle multiply ops
    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    // True for the multi-cycle divide ops
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// mul_div_unit_div_core: unsigned restoring divider, one quotient bit per
// cycle, WIDTH iterations after the start edge.
//   clk, rst      - clock, synchronous active-high reset
//   start         - load dividend/divisor magnitudes and begin
//   abort         - drop the division in flight
//   dividend      - unsigned dividend
//   divisor       - unsigned divisor (zero yields all-ones quotient)
//   quotient      - quotient, meaningful while valid is high
//   remainder     - remainder, meaningful while valid is high
//   valid         - one-cycle pulse after the final iteration
module mul_div_unit_div_core
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_valid;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // Partial remainder always stays below the divisor, so WIDTH+1 bits
    // hold the shifted value and the sign of the trial subtraction.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    // Iteration register: the dividend is shifted out of r_quo while
    // quotient bits are shifted in.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (start) begin
                r_rem <= '0;
                r_quo <= dividend;
                r_dvs <= divisor;
                r_cnt <= CNT_W'(WIDTH);
                r_run <= 1'b1;
            end else if (r_run) begin
                if (!w_diff[WIDTH]) begin
                    r_rem <= w_diff[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                end
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_run   <= 1'b0;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign valid     = r_valid;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with HI/LO registers for the
// EX stage. Multi-cycle MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
//   clk, rst   - clock, synchronous active-high reset
//   start      - EX holds a valid MDU instruction
//   op         - MDU op code (mdu_op_e)
//   src1, src2 - rs / rt operands
//   flush      - abort the operation in flight
//   stall_req  - combinational request to hold IF/ID/EX
//   busy       - mul/div in flight
//   done       - one-cycle pulse after HI/LO were written by mul/div
//   hi, lo     - HI/LO registers
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    mdu_state_e         r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_mul_signed;
    logic               r_div_zero;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_idle_take;
    logic               w_div_start;
    logic               w_div_signed;
    logic               w_s1_neg;
    logic               w_s2_neg;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_valid;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_is_mul    = is_mul_op(op);
    assign w_is_div    = is_div_op(op);
    assign w_idle_take = (r_state == ST_IDLE) && start && !flush;
    assign w_div_start = w_idle_take && w_is_div;

    // Divider runs on magnitudes; signs are re-applied after the last step.
    assign w_div_signed = (op == MDU_DIV);
    assign w_s1_neg     = w_div_signed && src1[WIDTH-1];
    assign w_s2_neg     = w_div_signed && src2[WIDTH-1];
    assign w_mag1       = w_s1_neg ? -src1 : src1;
    assign w_mag2       = w_s2_neg ? -src2 : src2;

    // Sign/zero-extend to 2*WIDTH so one unsigned multiply covers both
    // MULT and MULTU; the low 2*WIDTH bits are the exact product.
    assign w_a_ext = {{WIDTH{r_mul_signed && r_a[WIDTH-1]}}, r_a};
    assign w_b_ext = {{WIDTH{r_mul_signed && r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    mul_div_unit_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .abort     (flush),
        .dividend  (w_mag1),
        .divisor   (w_mag2),
        .quotient  (w_quo),
        .remainder (w_rem),
        .valid     (w_div_valid)
    );

    assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
    assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

    // Control FSM with HI/LO and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hi         <= '0;
            r_lo         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_mul_signed <= 1'b0;
            r_div_zero   <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_take) begin
                        if (w_is_mul) begin
                            r_a          <= src1;
                            r_b          <= src2;
                            r_mul_signed <= (op == MDU_MULT);
                            r_cnt        <= CNT_W'(MUL_LAT);
                            r_busy       <= 1'b1;
                            r_state      <= ST_MUL;
                        end else if (w_is_div) begin
                            // r_a keeps the raw dividend for the divide-by-zero result
                            r_a        <= src1;
                            r_div_zero <= (src2 == '0);
                            r_neg_q    <= w_s1_neg ^ w_s2_neg;
                            r_neg_r    <= w_s1_neg;
                            r_busy     <= 1'b1;
                            r_state    <= ST_DIV;
                        end else if (op == MDU_MTHI) begin
                            r_hi <= src1;
                        end else if (op == MDU_MTLO) begin
                            r_lo <= src1;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo    <= w_prod[WIDTH-1:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_div_valid) begin
                        if (r_div_zero) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start here is the retiring instruction itself
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_req = r_busy || (w_idle_take && (w_is_mul || w_is_div));
    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
